// File: rtl/seq_controller.sv
// seq_controller: fetches one instruction over req/ack, decodes it into registered
// datapath controls, issues them under valid/ready, halts stickily and counts retirements.
module seq_controller #(
  parameter int N     = 32,
  parameter int REG_W = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [N-1:0]     instr,
  output logic             ctl_valid,
  input  logic             ctl_ready,
  output logic [REG_W-1:0] r1,
  output logic [REG_W-1:0] r2,
  output logic [REG_W-1:0] w1,
  output logic [N-1:0]     imm,
  output logic             imm_flag,
  output logic [N-1:0]     mask,
  output logic             mem_read,
  output logic             mem_write,
  output logic             pc_read,
  output logic             is_jz,
  output logic             is_jg,
  output logic             is_halted,
  output logic [CNT_W-1:0] retired
);

  localparam int IMM_W = N - 6 - 3 * REG_W;

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_ADD    = 6'h01;
  localparam logic [5:0] OP_ADDI   = 6'h02;
  localparam logic [5:0] OP_LOADW  = 6'h03;
  localparam logic [5:0] OP_LOADB  = 6'h04;
  localparam logic [5:0] OP_STOREW = 6'h05;
  localparam logic [5:0] OP_STOREB = 6'h06;
  localparam logic [5:0] OP_MOVPC  = 6'h07;
  localparam logic [5:0] OP_JZ     = 6'h08;
  localparam logic [5:0] OP_JG     = 6'h09;

  localparam logic [N-1:0] MASK_BYTE = {{(N-8){1'b0}}, 8'hFF};

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
    logic [REG_W-1:0] w1;
    logic [N-1:0]     imm;
    logic             imm_flag;
    logic [N-1:0]     mask;
    logic             mem_read;
    logic             mem_write;
    logic             pc_read;
    logic             is_jz;
    logic             is_jg;
  } ctl_t;

  state_t           state_r, state_s;
  logic [N-1:0]     instr_r;
  logic [5:0]       opcode_s;
  ctl_t             dec_s, ctl_s, ctl_r;
  logic             dec_halt_s;
  logic             imem_req_s, imem_req_r;
  logic             ctl_valid_s, ctl_valid_r;
  logic             is_halted_s, is_halted_r;
  logic [CNT_W-1:0] retired_s, retired_r;

  // Decode the captured instruction word; HALT and every unlisted opcode halt.
  always_comb begin
    dec_s      = '0;
    dec_halt_s = 1'b0;
    opcode_s   = instr_r[N-1 -: 6];
    dec_s.w1   = instr_r[N-7 -: REG_W];
    dec_s.r1   = instr_r[N-7-REG_W -: REG_W];
    dec_s.r2   = instr_r[N-7-2*REG_W -: REG_W];
    dec_s.imm  = {{(N-IMM_W){instr_r[IMM_W-1]}}, instr_r[IMM_W-1:0]};
    case (opcode_s)
      OP_NOP:    dec_s.mask = '0;
      OP_ADD:    dec_s.mask = '1;
      OP_ADDI:   begin dec_s.imm_flag = 1'b1; dec_s.mask = '1; end
      OP_LOADW:  begin dec_s.mem_read = 1'b1; dec_s.imm_flag = 1'b1; dec_s.mask = '1; end
      OP_LOADB:  begin dec_s.mem_read = 1'b1; dec_s.imm_flag = 1'b1; dec_s.mask = MASK_BYTE; end
      OP_STOREW: begin dec_s.mem_write = 1'b1; dec_s.imm_flag = 1'b1; dec_s.mask = '1; end
      OP_STOREB: begin dec_s.mem_write = 1'b1; dec_s.imm_flag = 1'b1; dec_s.mask = MASK_BYTE; end
      OP_MOVPC:  begin dec_s.pc_read = 1'b1; dec_s.mask = '1; end
      OP_JZ:     begin dec_s.is_jz = 1'b1; dec_s.imm_flag = 1'b1; end
      OP_JG:     begin dec_s.is_jg = 1'b1; dec_s.imm_flag = 1'b1; end
      default:   dec_halt_s = 1'b1;
    endcase
  end

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s   = state_r;
    ctl_s     = ctl_r;
    retired_s = retired_r;
    case (state_r)
      S_FETCH: begin
        if (imem_ack) state_s = S_DECODE;
        else          state_s = S_FETCH;
      end
      S_DECODE: begin
        if (dec_halt_s) begin
          state_s = S_HALT;
          ctl_s   = '0;
        end else begin
          state_s = S_ISSUE;
          ctl_s   = dec_s;
        end
      end
      S_ISSUE: begin
        if (ctl_ready) begin
          state_s   = S_FETCH;
          ctl_s     = '0;
          retired_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_HALT: begin
        state_s = S_HALT;
        ctl_s   = '0;
      end
      default: begin
        state_s = S_FETCH;
        ctl_s   = '0;
      end
    endcase
    imem_req_s  = (state_s == S_FETCH);
    ctl_valid_s = (state_s == S_ISSUE);
    is_halted_s = (state_s == S_HALT);
  end

  // State, captured instruction and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FETCH;
      instr_r     <= '0;
      ctl_r       <= '0;
      imem_req_r  <= 1'b1;
      ctl_valid_r <= 1'b0;
      is_halted_r <= 1'b0;
      retired_r   <= '0;
    end else begin
      state_r     <= state_s;
      if (state_r == S_FETCH && imem_ack) instr_r <= instr;
      else                                instr_r <= instr_r;
      ctl_r       <= ctl_s;
      imem_req_r  <= imem_req_s;
      ctl_valid_r <= ctl_valid_s;
      is_halted_r <= is_halted_s;
      retired_r   <= retired_s;
    end
  end

  assign imem_req  = imem_req_r;
  assign ctl_valid = ctl_valid_r;
  assign is_halted = is_halted_r;
  assign retired   = retired_r;
  assign r1        = ctl_r.r1;
  assign r2        = ctl_r.r2;
  assign w1        = ctl_r.w1;
  assign imm       = ctl_r.imm;
  assign imm_flag  = ctl_r.imm_flag;
  assign mask      = ctl_r.mask;
  assign mem_read  = ctl_r.mem_read;
  assign mem_write = ctl_r.mem_write;
  assign pc_read   = ctl_r.pc_read;
  assign is_jz     = ctl_r.is_jz;
  assign is_jg     = ctl_r.is_jg;

endmodule
